fsm_sync_sequencer: RTL and testbench
=====================================

Name: fsm_sync_sequencer

Overview:
Parametrised multi-channel successor of the single-trigger calibration sequencer. On a start edge, waits for a frame-grabber (FG) edge, then a fixed open delay, then fires N_CH trigger pulses, each at its own programmable delay after a phase edge. Repeats the phase-locked burst n_shots times per start. Optional wait timeouts. Sits between the synchronisation inputs and the detector/camera trigger lines.

Parameters:
N_CH, 4, number of trigger output channels
CNT_W, 32, width of counter and per-channel delays
FG_DELAY, 400000, cycles spent in FG_DELAY state (>=1)
TRIGGER_LEN, 100, trigger pulse length in cycles (>=1)
SHOT_W, 8, width of shot count
TIMEOUT, 10000000, max wait cycles in WAIT_FG / WAIT_PHASE (FSM_TIMEOUT_EN only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start_signal  in  1  start request, rising-edge active
abort_signal  in  1  abort, rising-edge active
fg_signal  in  1  frame-grabber strobe, rising-edge active
phase_signal  in  1  phase reference, rising-edge active
n_shots  in  SHOT_W  bursts per start; 0 treated as 1
ch_delay  in  N_CH*CNT_W  per-channel delay, channel k at [k*CNT_W +: CNT_W]
ch_enable  in  N_CH  per-channel enable
output_trigger  out  N_CH  registered trigger pulses
busy  out  1  high whenever state != IDLE
done_pulse  out  1  one-cycle pulse after the last burst
timeout_err  out  1  sticky timeout flag
scenario_state  out  3  current state encoding
counter_out  out  CNT_W  current counter value
shot_out  out  SHOT_W  bursts completed in the current run

Behaviour:
- Reset (reset==0 at clock edge): state IDLE, counter 0, shot count 0, all outputs 0, edge histories set to 2'b11 (input already high at release gives no edge).
- Edge detection: per input, 2-bit history shifted each clock; edge = history==2'b01. State reacts on the 2nd clock edge after an input rises.
- Encoding: IDLE=0, WAIT_FG=1, FG_DELAY=2, WAIT_PHASE=3, FIRE=4; other codes -> IDLE.
- IDLE: start edge -> latch n_shots, ch_delay, ch_enable; clear timeout_err, shot count, counter; go to WAIT_FG.
- WAIT_FG: fg edge -> FG_DELAY, counter 0. A phase edge in the same cycle is ignored.
- FG_DELAY: counter counts 0..FG_DELAY-1 (exactly FG_DELAY cycles), then goes to WAIT_PHASE with counter 0.
- WAIT_PHASE: phase edge -> FIRE with counter 0.
- FIRE:
  - counter increments each cycle.
  - win_end = max(latched delay of enabled channels) + TRIGGER_LEN, computed in CNT_W+1 bits; win_end = TRIGGER_LEN if no channel is enabled.
  - output_trigger[k] <= en_k && cnt >= d_k && cnt < d_k+TRIGGER_LEN. Channel k rises d_k+1 clock edges after FIRE entry and stays high exactly TRIGGER_LEN cycles.
  - At cnt == win_end-1: shot count +1. If shots done < n_shots -> WAIT_PHASE (no FG re-wait). Else -> IDLE and done_pulse=1 for one cycle.
  - Phase edges during FIRE are ignored, not queued.
- Start edge while busy: ignored. Changes to config inputs while busy: ignored.
- Abort edge in any non-IDLE state -> IDLE at the next edge. output_trigger cleared at that same edge. No done_pulse. timeout_err unchanged.
- Priority: reset > abort > timeout > normal transitions.
- counter_out and shot_out reflect internal registers. Counter is 0 in IDLE.

Optional Feature:
FSM_TIMEOUT_EN:
- Defined: the counter runs in WAIT_FG and WAIT_PHASE. If it reaches TIMEOUT-1 without the awaited edge, the block sets timeout_err (sticky) and goes to IDLE, with no done_pulse. timeout_err clears on the next start edge or on reset.
- Undefined: waits are unbounded, counter holds 0 in the wait states, and timeout_err is tied 0 (port kept).

Test Plan:
(All tests use N_CH=2, FG_DELAY=10, TRIGGER_LEN=4, TIMEOUT=50.)
- Basic: d={3,0}, en=11, n_shots=1; start, fg, phase -> ch1 high FIRE cycles 1-4, ch0 high 4-7, exactly 4 cycles each; done_pulse once; busy falls with done.
- Repeat: n_shots=3, d={0,0}; start, fg, then 3 phase edges spaced 20 cycles -> 3 pulse pairs, no extra FG wait; shot_out 1,2,3; single done_pulse after the 3rd.
- Disabled/zero: en=01, n_shots=0 -> one burst, ch1 never high; fire window is ch0 delay+4.
- Abort: abort mid-pulse in FIRE -> output_trigger 0 and state IDLE at the next edge; no done_pulse; a new start runs normally.
- Timeout (FSM_TIMEOUT_EN): start, no fg for 50 cycles -> timeout_err=1, state IDLE; next start clears it.
- Reset: reset low during FIRE with phase_signal held high -> all outputs 0; after release no spurious edge; start ignored while reset low.

Source files
------------

// File: rtl/fsm_sync_sequencer_if.sv
// fsm_sync_sequencer_if: sync inputs, burst configuration and trigger/status outputs of the sequencer.
interface fsm_sync_sequencer_if #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32,
    parameter int SHOT_W = 8
);
    logic                    start_signal;
    logic                    abort_signal;
    logic                    fg_signal;
    logic                    phase_signal;
    logic [SHOT_W-1:0]       n_shots;
    logic [N_CH*CNT_W-1:0]   ch_delay;
    logic [N_CH-1:0]         ch_enable;
    logic [N_CH-1:0]         output_trigger;
    logic                    busy;
    logic                    done_pulse;
    logic                    timeout_err;
    logic [2:0]              scenario_state;
    logic [CNT_W-1:0]        counter_out;
    logic [SHOT_W-1:0]       shot_out;

    modport master (
        output start_signal, abort_signal, fg_signal, phase_signal, n_shots, ch_delay, ch_enable,
        input  output_trigger, busy, done_pulse, timeout_err, scenario_state, counter_out, shot_out
    );

    modport slave (
        input  start_signal, abort_signal, fg_signal, phase_signal, n_shots, ch_delay, ch_enable,
        output output_trigger, busy, done_pulse, timeout_err, scenario_state, counter_out, shot_out
    );
endinterface

// File: rtl/fsm_sync_sequencer.sv
// fsm_sync_sequencer: FG-armed, phase-locked multi-channel trigger burst sequencer.
// Define FSM_TIMEOUT_EN to bound the FG/phase waits and raise a sticky timeout_err.
module fsm_sync_sequencer #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int FG_DELAY    = 400000,
    parameter int TRIGGER_LEN = 100,
    parameter int SHOT_W      = 8,
    parameter int TIMEOUT     = 10000000
) (
    input logic                  clock,
    input logic                  reset,
    fsm_sync_sequencer_if.slave  bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_FG    = 3'd1;
    localparam logic [2:0] FG_DELAY_S = 3'd2;
    localparam logic [2:0] WAIT_PHASE = 3'd3;
    localparam logic [2:0] FIRE       = 3'd4;
    localparam logic [CNT_W:0]   TL_W    = (CNT_W+1)'(TRIGGER_LEN);
    localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FG_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`ifdef FSM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SHOT_W-1:0]     shot_q, shot_d, nsh_q, nsh_d, shot_inc;
    logic [N_CH*CNT_W-1:0] dly_q, dly_d;
    logic [N_CH-1:0]       en_q, en_d, trig_q, trig_d, win;
    logic                  done_q, done_d, terr_q, terr_d;
    logic [1:0]            st_h_q, ab_h_q, fg_h_q, ph_h_q;
    logic                  start_e, abort_e, fg_e, phase_e;
    logic [CNT_W-1:0]      max_dly;
    logic [CNT_W:0]        win_end;

    assign start_e  = st_h_q == 2'b01;
    assign abort_e  = ab_h_q == 2'b01;
    assign fg_e     = fg_h_q == 2'b01;
    assign phase_e  = ph_h_q == 2'b01;
    assign shot_inc = shot_q + 1'b1;

    // Burst window spans the latest enabled channel; an all-disabled burst still lasts TRIGGER_LEN.
    always_comb begin
        max_dly = '0;
        win     = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (en_q[k] && dly_q[k*CNT_W +: CNT_W] > max_dly) max_dly = dly_q[k*CNT_W +: CNT_W];
            win[k] = en_q[k] && cnt_q >= dly_q[k*CNT_W +: CNT_W]
                     && {1'b0, cnt_q} < {1'b0, dly_q[k*CNT_W +: CNT_W]} + TL_W;
        end
        win_end = {1'b0, max_dly} + TL_W;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shot_d  = shot_q;
        nsh_d   = nsh_q;
        dly_d   = dly_q;
        en_d    = en_q;
        trig_d  = '0;
        done_d  = 1'b0;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_e) begin
                    state_d = WAIT_FG;
                    nsh_d   = bus.n_shots == '0 ? SHOT_W'(1) : bus.n_shots;
                    dly_d   = bus.ch_delay;
                    en_d    = bus.ch_enable;
                    terr_d  = 1'b0;
                    shot_d  = '0;
                end
            end
            WAIT_FG: begin
                state_d = fg_e ? FG_DELAY_S : WAIT_FG;
                cnt_d   = fg_e ? '0 : (TO_EN ? cnt_q + 1'b1 : cnt_q);
            end
            FG_DELAY_S: begin
                state_d = cnt_q == FG_LAST ? WAIT_PHASE : FG_DELAY_S;
                cnt_d   = cnt_q == FG_LAST ? '0 : cnt_q + 1'b1;
            end
            WAIT_PHASE: begin
                state_d = phase_e ? FIRE : WAIT_PHASE;
                cnt_d   = phase_e ? '0 : (TO_EN ? cnt_q + 1'b1 : cnt_q);
            end
            FIRE: begin
                trig_d = win;
                cnt_d  = cnt_q + 1'b1;
                if ({1'b0, cnt_q} == win_end - 1'b1) begin
                    shot_d  = shot_inc;
                    cnt_d   = '0;
                    state_d = shot_inc >= nsh_q ? IDLE : WAIT_PHASE;
                    done_d  = shot_inc >= nsh_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (TO_EN && (state_q == WAIT_FG || state_q == WAIT_PHASE) && cnt_q == TO_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            terr_d  = 1'b1;
        end
        if (abort_e && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            trig_d  = '0;
            done_d  = 1'b0;
            terr_d  = terr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shot_q  <= '0;
            nsh_q   <= '0;
            dly_q   <= '0;
            en_q    <= '0;
            trig_q  <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            st_h_q  <= 2'b11;
            ab_h_q  <= 2'b11;
            fg_h_q  <= 2'b11;
            ph_h_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shot_q  <= shot_d;
            nsh_q   <= nsh_d;
            dly_q   <= dly_d;
            en_q    <= en_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            st_h_q  <= {st_h_q[0], bus.start_signal};
            ab_h_q  <= {ab_h_q[0], bus.abort_signal};
            fg_h_q  <= {fg_h_q[0], bus.fg_signal};
            ph_h_q  <= {ph_h_q[0], bus.phase_signal};
        end
    end

    assign bus.output_trigger = trig_q;
    assign bus.busy           = state_q != IDLE;
    assign bus.done_pulse     = done_q;
    assign bus.timeout_err    = terr_q;
    assign bus.scenario_state = state_q;
    assign bus.counter_out    = cnt_q;
    assign bus.shot_out       = shot_q;
endmodule

// File: tb/tb_fsm_sync_sequencer.sv
// tb_fsm_sync_sequencer: directed checks of the sequencer with N_CH=2, FG_DELAY=10, TRIGGER_LEN=4, TIMEOUT=50.
module tb_fsm_sync_sequencer;
    logic clock;
    logic reset;
    int   n_chk;
    int   n_err;

    fsm_sync_sequencer_if #(.N_CH(2), .CNT_W(32), .SHOT_W(8)) bus ();

    fsm_sync_sequencer #(
        .N_CH(2), .CNT_W(32), .FG_DELAY(10), .TRIGGER_LEN(4), .SHOT_W(8), .TIMEOUT(50)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic edge_start();
        bus.start_signal = 1'b1;
        tick();
        bus.start_signal = 1'b0;
        tick();
    endtask

    task automatic edge_fg();
        bus.fg_signal = 1'b1;
        tick();
        bus.fg_signal = 1'b0;
        tick();
    endtask

    task automatic edge_phase();
        bus.phase_signal = 1'b1;
        tick();
        bus.phase_signal = 1'b0;
        tick();
    endtask

    task automatic edge_abort();
        bus.abort_signal = 1'b1;
        tick();
        bus.abort_signal = 1'b0;
        tick();
    endtask

    task automatic run_to_fire(input logic [7:0] n, input logic [63:0] d, input logic [1:0] en);
        bus.n_shots   = n;
        bus.ch_delay  = d;
        bus.ch_enable = en;
        edge_start();
        edge_fg();
        repeat (10) tick();
        edge_phase();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_chk++; if (bus.scenario_state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", bus.scenario_state); end
        n_chk++; if ({bus.output_trigger, bus.busy, bus.done_pulse, bus.timeout_err} !== 5'b0) begin n_err++; $display("FAIL reset_outs got %b want 00000", {bus.output_trigger, bus.busy, bus.done_pulse, bus.timeout_err}); end
        n_chk++; if (bus.counter_out !== 32'd0 || bus.shot_out !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.counter_out, bus.shot_out); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] et [8];
        logic       ed [8];
        et = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};
        ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.n_shots   = 8'd1;
        bus.ch_delay  = {32'd0, 32'd3};
        bus.ch_enable = 2'b11;
        edge_start();
        n_chk++; if (bus.scenario_state !== 3'd1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_wait_fg got %0d/%b want 1/1", bus.scenario_state, bus.busy); end
        bus.n_shots   = 8'd5;
        bus.ch_delay  = {32'd9, 32'd9};
        bus.ch_enable = 2'b00;
        bus.fg_signal = 1'b1;
        bus.phase_signal = 1'b1;
        tick();
        bus.fg_signal = 1'b0;
        bus.phase_signal = 1'b0;
        tick();
        n_chk++; if (bus.scenario_state !== 3'd2 || bus.counter_out !== 32'd0) begin n_err++; $display("FAIL basic_fg_delay got %0d/%0d want 2/0", bus.scenario_state, bus.counter_out); end
        repeat (9) tick();
        n_chk++; if (bus.scenario_state !== 3'd2 || bus.counter_out !== 32'd9) begin n_err++; $display("FAIL basic_fg_last got %0d/%0d want 2/9", bus.scenario_state, bus.counter_out); end
        tick();
        n_chk++; if (bus.scenario_state !== 3'd3 || bus.counter_out !== 32'd0) begin n_err++; $display("FAIL basic_wait_phase got %0d/%0d want 3/0", bus.scenario_state, bus.counter_out); end
        repeat (2) tick();
        n_chk++; if (bus.scenario_state !== 3'd3) begin n_err++; $display("FAIL basic_phase_not_queued got %0d want 3", bus.scenario_state); end
        edge_phase();
        n_chk++; if (bus.scenario_state !== 3'd4 || bus.counter_out !== 32'd0) begin n_err++; $display("FAIL basic_fire got %0d/%0d want 4/0", bus.scenario_state, bus.counter_out); end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_chk++; if (bus.output_trigger !== et[k]) begin n_err++; $display("FAIL basic_trig c%0d got %b want %b", k + 1, bus.output_trigger, et[k]); end
            n_chk++; if (bus.done_pulse !== ed[k]) begin n_err++; $display("FAIL basic_done c%0d got %b want %b", k + 1, bus.done_pulse, ed[k]); end
            if (k == 6) begin
                n_chk++; if (bus.scenario_state !== 3'd0 || bus.busy !== 1'b0 || bus.shot_out !== 8'd1) begin n_err++; $display("FAIL basic_end got %0d/%b/%0d want 0/0/1", bus.scenario_state, bus.busy, bus.shot_out); end
            end
        end
    endtask

    task automatic test_repeat();
        run_to_fire(8'd3, 64'd0, 2'b11);
        for (int s = 0; s < 3; s++) begin
            if (s > 0) edge_phase();
            n_chk++; if (bus.scenario_state !== 3'd4) begin n_err++; $display("FAIL rep_fire s%0d got %0d want 4", s, bus.scenario_state); end
            for (int k = 0; k < 4; k++) begin
                tick();
                n_chk++; if (bus.output_trigger !== 2'b11) begin n_err++; $display("FAIL rep_trig s%0d c%0d got %b want 11", s, k + 1, bus.output_trigger); end
                if (k < 3) begin
                    n_chk++; if (bus.done_pulse !== 1'b0) begin n_err++; $display("FAIL rep_early_done s%0d c%0d got 1 want 0", s, k + 1); end
                end
            end
            n_chk++; if (bus.shot_out !== 8'(s + 1)) begin n_err++; $display("FAIL rep_shot s%0d got %0d want %0d", s, bus.shot_out, s + 1); end
            n_chk++; if (bus.scenario_state !== (s == 2 ? 3'd0 : 3'd3) || bus.done_pulse !== (s == 2)) begin n_err++; $display("FAIL rep_end s%0d got %0d/%b want %0d/%b", s, bus.scenario_state, bus.done_pulse, s == 2 ? 0 : 3, s == 2); end
            tick();
            n_chk++; if (bus.output_trigger !== 2'b00 || bus.done_pulse !== 1'b0) begin n_err++; $display("FAIL rep_after s%0d got %b/%b want 00/0", s, bus.output_trigger, bus.done_pulse); end
            if (s == 0) begin
                edge_start();
                n_chk++; if (bus.scenario_state !== 3'd3 || bus.shot_out !== 8'd1) begin n_err++; $display("FAIL rep_busy_start got %0d/%0d want 3/1", bus.scenario_state, bus.shot_out); end
            end
            repeat (12) tick();
            n_chk++; if (bus.scenario_state !== (s == 2 ? 3'd0 : 3'd3) || bus.done_pulse !== 1'b0) begin n_err++; $display("FAIL rep_idle s%0d got %0d/%b want %0d/0", s, bus.scenario_state, bus.done_pulse, s == 2 ? 0 : 3); end
        end
    endtask

    task automatic test_disabled_zero();
        logic [1:0] et [7];
        et = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        run_to_fire(8'd0, {32'd5, 32'd2}, 2'b01);
        for (int k = 0; k < 7; k++) begin
            tick();
            n_chk++; if (bus.output_trigger !== et[k]) begin n_err++; $display("FAIL dis_trig c%0d got %b want %b", k + 1, bus.output_trigger, et[k]); end
            if (k == 4) begin
                n_chk++; if (bus.scenario_state !== 3'd4) begin n_err++; $display("FAIL dis_window got %0d want 4", bus.scenario_state); end
            end
            if (k == 5) begin
                n_chk++; if (bus.scenario_state !== 3'd0 || bus.done_pulse !== 1'b1 || bus.shot_out !== 8'd1) begin n_err++; $display("FAIL dis_end got %0d/%b/%0d want 0/1/1", bus.scenario_state, bus.done_pulse, bus.shot_out); end
            end
        end
    endtask

    task automatic test_abort();
        run_to_fire(8'd2, 64'd0, 2'b11);
        repeat (2) tick();
        bus.abort_signal = 1'b1;
        tick();
        n_chk++; if (bus.output_trigger !== 2'b11 || bus.scenario_state !== 3'd4) begin n_err++; $display("FAIL abort_pre got %b/%0d want 11/4", bus.output_trigger, bus.scenario_state); end
        bus.abort_signal = 1'b0;
        tick();
        n_chk++; if (bus.output_trigger !== 2'b00 || bus.scenario_state !== 3'd0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got %b/%0d/%b want 00/0/0", bus.output_trigger, bus.scenario_state, bus.busy); end
        n_chk++; if (bus.done_pulse !== 1'b0 || bus.counter_out !== 32'd0) begin n_err++; $display("FAIL abort_done got %b/%0d want 0/0", bus.done_pulse, bus.counter_out); end
        tick();
        n_chk++; if (bus.done_pulse !== 1'b0) begin n_err++; $display("FAIL abort_no_done got 1 want 0"); end
        run_to_fire(8'd1, {32'd1, 32'd0}, 2'b11);
        repeat (5) tick();
        n_chk++; if (bus.scenario_state !== 3'd0 || bus.done_pulse !== 1'b1 || bus.output_trigger !== 2'b10) begin n_err++; $display("FAIL abort_rerun got %0d/%b/%b want 0/1/10", bus.scenario_state, bus.done_pulse, bus.output_trigger); end
        tick();
    endtask

    task automatic test_timeout();
        bus.n_shots   = 8'd1;
        bus.ch_delay  = 64'd0;
        bus.ch_enable = 2'b11;
        edge_start();
`ifdef FSM_TIMEOUT_EN
        repeat (49) tick();
        n_chk++; if (bus.scenario_state !== 3'd1 || bus.counter_out !== 32'd49) begin n_err++; $display("FAIL to_wait got %0d/%0d want 1/49", bus.scenario_state, bus.counter_out); end
        tick();
        n_chk++; if (bus.scenario_state !== 3'd0 || bus.timeout_err !== 1'b1 || bus.done_pulse !== 1'b0) begin n_err++; $display("FAIL to_fire got %0d/%b/%b want 0/1/0", bus.scenario_state, bus.timeout_err, bus.done_pulse); end
        repeat (3) tick();
        n_chk++; if (bus.timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got 0 want 1"); end
        edge_start();
        n_chk++; if (bus.scenario_state !== 3'd1 || bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear got %0d/%b want 1/0", bus.scenario_state, bus.timeout_err); end
`else
        repeat (60) tick();
        n_chk++; if (bus.scenario_state !== 3'd1 || bus.counter_out !== 32'd0 || bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL to_unbounded got %0d/%0d/%b want 1/0/0", bus.scenario_state, bus.counter_out, bus.timeout_err); end
`endif
        edge_abort();
        n_chk++; if (bus.scenario_state !== 3'd0) begin n_err++; $display("FAIL to_abort got %0d want 0", bus.scenario_state); end
    endtask

    task automatic test_reset_fire();
        bus.n_shots   = 8'd1;
        bus.ch_delay  = 64'd0;
        bus.ch_enable = 2'b11;
        edge_start();
        edge_fg();
        repeat (10) tick();
        bus.phase_signal = 1'b1;
        repeat (4) tick();
        n_chk++; if (bus.scenario_state !== 3'd4 || bus.output_trigger !== 2'b11) begin n_err++; $display("FAIL rst_pre got %0d/%b want 4/11", bus.scenario_state, bus.output_trigger); end
        reset = 1'b0;
        tick();
        n_chk++; if ({bus.scenario_state, bus.output_trigger, bus.busy, bus.done_pulse, bus.timeout_err} !== 8'b0 || bus.counter_out !== 32'd0 || bus.shot_out !== 8'd0) begin n_err++; $display("FAIL rst_fire got %0d/%b/%b/%0d want 0/00/0/0", bus.scenario_state, bus.output_trigger, bus.busy, bus.counter_out); end
        bus.start_signal = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        n_chk++; if (bus.scenario_state !== 3'd0 || bus.output_trigger !== 2'b00 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_release got %0d/%b/%b want 0/00/0", bus.scenario_state, bus.output_trigger, bus.busy); end
        bus.start_signal = 1'b0;
        bus.phase_signal = 1'b0;
        tick();
        edge_start();
        n_chk++; if (bus.scenario_state !== 3'd1) begin n_err++; $display("FAIL rst_restart got %0d want 1", bus.scenario_state); end
        edge_abort();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        bus.start_signal = 1'b0;
        bus.abort_signal = 1'b0;
        bus.fg_signal    = 1'b0;
        bus.phase_signal = 1'b0;
        bus.n_shots      = 8'd0;
        bus.ch_delay     = 64'd0;
        bus.ch_enable    = 2'b00;
        test_reset();
        test_basic();
        test_repeat();
        test_disabled_zero();
        test_abort();
        test_timeout();
        test_reset_fire();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
